// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures memory read data into an IR and hands it to decode.
// Optional halt-on-opcode-6'b111111 behaviour is enabled by defining FETCH_HALT_EN.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 256
`endif

module fetch_unit #(
  parameter int unsigned             PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0]     RESET_PC  = '0,
  parameter int unsigned             CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_WIDTH-1:0]   mem_address,
  output logic                  mem_write,
  input  logic [`WORD_SIZE-1:0] mem_data_out,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  ir_ready,
  output logic                  ir_valid,
  output logic [`WORD_SIZE-1:0] ir,
  output logic [PC_WIDTH-1:0]   ir_pc,
  output logic [CNT_WIDTH-1:0]  fetch_count,
  output logic                  halted
);

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [`WORD_SIZE-1:0] ir_q, ir_d;
  logic [PC_WIDTH-1:0]   ir_pc_q, ir_pc_d;
  logic                  ir_valid_q, ir_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic                  run;
  logic                  load;

`ifdef FETCH_HALT_EN
  typedef enum logic {RUN, HALT} state_e;
  state_e state_q, state_d;

  assign run    = (state_q == RUN);
  assign halted = (state_q == HALT);
`else
  assign run    = 1'b1;
  assign halted = 1'b0;
`endif

  assign load   = run && (!ir_valid_q || ir_ready) && !redirect;
  // The last memory word wraps back to address 0.
  assign pc_inc = (pc_q == PC_WIDTH'(`MEM_SIZE - 1)) ? '0 : pc_q + PC_WIDTH'(1);

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;
`ifdef FETCH_HALT_EN
    state_d    = state_q;
`endif
    if (redirect) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
`ifdef FETCH_HALT_EN
      state_d    = RUN;
`endif
    end else if (load) begin
      ir_d       = mem_data_out;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
`ifdef FETCH_HALT_EN
      // A halt word is delivered to decode but the PC parks on it.
      if (mem_data_out[31:26] == 6'b111111) begin
        state_d = HALT;
      end else begin
        pc_d = pc_inc;
      end
`else
      pc_d = pc_inc;
`endif
    end else if (ir_valid_q && ir_ready) begin
      ir_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
`ifdef FETCH_HALT_EN
      state_q    <= RUN;
`endif
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
`ifdef FETCH_HALT_EN
      state_q    <= state_d;
`endif
    end
  end

  assign mem_address = pc_q;
  assign mem_write   = 1'b0;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_count = cnt_q;

endmodule
